tlc_phase_scheduler: RTL
========================

# tlc_phase_scheduler

Density-aware phase scheduler for the four-approach junction: main pair m1/m2 and side roads s1/s2. It sequences green, yellow and all-red clearance intervals from one internal phase timer. It latches side-road density requests and stretches main green according to a main-road density level. All lamps are driven from registered state, so it replaces the mux/DFF sequencing network around the existing lamp decode.

## Interface
Parameters:
- CW, 4: phase timer width; timer saturates at 2^CW-1.
- T_MIN_GREEN, 4: minimum green cycles, any phase.
- T_EXT, 2: main-green extension cycles per unit of d_main.
- T_MAX_GREEN, 12: maximum green cycles. Must be ≥ T_MIN_GREEN and ≤ 2^CW-1.
- T_YELLOW, 3: yellow cycles.
- T_ALLRED, 1: all-red clearance cycles.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- p1  input  1  side-road 1 density request (level).
- p2  input  1  side-road 2 density request (level).
- d_main  input  2  main-road density level, 0..3.
- m1_lt, m2_lt, s1_lt, s2_lt  output  3 each  lamps as {red, yellow, green}; exactly one bit set at all times.
- phase  output  2  0 = main, 1 = s1, 2 = s2, 3 = clearance/ped.

## Operation
- States: INIT_RED, MAIN_G, MAIN_Y, CLR_M, S1_G, S1_Y, CLR_1, S2_G, S2_Y, CLR_2, plus PED_W when the pedestrian feature is compiled in.
- Timer: set to 0 on every state change; increments by 1 otherwise; saturates.
- Request latches req1/req2:
  - Set whenever p1/p2 is high.
  - Cleared on entry to S1_G/S2_G respectively.
  - Set-and-clear in the same cycle: clear wins. p still high in S1_G re-sets req1 the next cycle.
- Green limit: g_lim = min(T_MIN_GREEN + d_main*T_EXT, T_MAX_GREEN). d_main is sampled every cycle.
- Transitions, evaluated on the current timer value:
  - INIT_RED → MAIN_G at timer = T_ALLRED-1.
  - MAIN_G → MAIN_Y when (req1|req2) and timer ≥ g_lim-1. With no request, MAIN_G holds indefinitely.
  - MAIN_Y → CLR_M at timer = T_YELLOW-1.
  - CLR_M → S1_G if req1, else S2_G if req2, else MAIN_G. The exit fires at timer = T_ALLRED-1.
  - S1_G/S2_G → yellow when timer ≥ T_MIN_GREEN-1 and (own p low or timer ≥ T_MAX_GREEN-1).
  - S1_Y → CLR_1 and S2_Y → CLR_2 at timer = T_YELLOW-1.
  - CLR_1 → S2_G if req2, else MAIN_G.
  - CLR_2 → MAIN_G.
- Simultaneous p1 and p2: s1 is served first, then s2, then main.
- Lamps: only the approach(es) owning the state show green or yellow; all others show red. MAIN_* drives m1 and m2 identically. INIT_RED and CLR_* show all red.

## Timing
- Reset (rst=0 at an edge): state INIT_RED, timer 0, req latches 0, all lamps 3'b100, phase 3. Reset is effective from any state, including mid-yellow.
- Outputs are registered. Lamps and phase change on the same edge as the state; there is no combinational path from inputs to outputs.
- A request high at edge k is latched at edge k. It can end MAIN_G at edge k+1 at the earliest.
- State with duration N occupies exactly N cycles. Minimum full cycle main→s1→main is g_lim + T_YELLOW + T_ALLRED + T_MIN_GREEN + T_YELLOW + T_ALLRED.

## Configuration
- TLC_PED_PHASE_EN defined:
  - Adds input ped_req (1 bit) and output walk (1 bit), plus parameter T_WALK, default 6.
  - ped_req is latched like p1/p2.
  - CLR_M goes to PED_W first if reqp is set. PED_W shows all red, walk=1 for T_WALK cycles, clears reqp on entry, then applies the normal CLR_M side-selection rule.
  - walk resets to 0.
- Macro undefined: no ped ports, no PED_W state; behaviour exactly as above.

## Structure
- Package tlc_sched_pkg holds:
  - state enum;
  - lamp constants LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001;
  - phase codes.
- Sub-module phase_timer: CW-bit saturating counter with synchronous clear and the same reset.

## Test plan
- Reset and startup: rst=0 for 3 cycles → all lamps 100, phase 3. First edge with rst=1 → MAIN_G, m1_lt=m2_lt=001.
- Idle main: no p1/p2 for 100 cycles → main green throughout, s1_lt=s2_lt=100.
- Single s1 request: d_main=0, 1-cycle p1 pulse at MAIN_G timer 5 → main yellow 3 cycles, all red 1, s1 green 4, s1 yellow 3, all red 1, then MAIN_G.
- Both requests with density: d_main=3, p1=p2=1 held from MAIN_G entry → main green 10, s1 green 12, s2 green 12, then main green 10 again.
- Reset mid-operation: rst=0 during S1_Y → next edge all red, req latches 0. Recovery to MAIN_G with no side service despite the earlier p1.
- With TLC_PED_PHASE_EN: ped_req and p2 pulsed in MAIN_G → PED_W walk=1 for 6 cycles, all vehicle lamps red, then S2_G.

Source files
------------

// File: rtl/tlc_sched_pkg.sv
// Shared types and constants for the junction phase scheduler.
// Optional pedestrian phase: define TLC_PED_PHASE_EN to add the PED_W state.
package tlc_sched_pkg;

  typedef enum logic [3:0] {
    INIT_RED = 4'd0,
    MAIN_G   = 4'd1,
    MAIN_Y   = 4'd2,
    CLR_M    = 4'd3,
    S1_G     = 4'd4,
    S1_Y     = 4'd5,
    CLR_1    = 4'd6,
    S2_G     = 4'd7,
    S2_Y     = 4'd8,
    CLR_2    = 4'd9
`ifdef TLC_PED_PHASE_EN
    ,
    PED_W    = 4'd10
`endif
  } sched_state_t;

  // Lamp encoding {red, yellow, green}; exactly one bit is ever set.
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Phase codes reported on the phase output.
  localparam logic [1:0] PH_MAIN = 2'd0;
  localparam logic [1:0] PH_S1   = 2'd1;
  localparam logic [1:0] PH_S2   = 2'd2;
  localparam logic [1:0] PH_CLR  = 2'd3;

  // Lamp for an approach that owns green state g and yellow state y.
  function automatic logic [2:0] lamp_of(sched_state_t st, sched_state_t g, sched_state_t y);
    if (st == g)      return LT_GRN;
    else if (st == y) return LT_YEL;
    else              return LT_RED;
  endfunction

  // Phase code for a state; anything not owned by an approach is clearance.
  function automatic logic [1:0] phase_of(sched_state_t st);
    case (st)
      MAIN_G, MAIN_Y: return PH_MAIN;
      S1_G, S1_Y:     return PH_S1;
      S2_G, S2_Y:     return PH_S2;
      default:        return PH_CLR;
    endcase
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_phase_timer.sv
// Saturating phase timer: counts cycles spent in the current state.
// Cleared synchronously on every state change; holds at all-ones.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [CW-1:0] count
);

  // Count up, clear on request, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Density-aware phase scheduler for a four-approach junction (m1/m2 main,
// s1/s2 side). One FSM sequences green / yellow / all-red intervals from a
// shared phase timer; side requests are latched, main green is stretched by
// the main-road density level.
// Optional pedestrian phase: define TLC_PED_PHASE_EN (adds ped_req, walk,
// T_WALK and the PED_W state entered after main clearance).
//
// Handshake: p1, p2 (and ped_req) are level requests with no acknowledge;
// a level seen high at a clock edge is held in a latch until the matching
// green (or walk) state is entered, at which point the latch clears.
module tlc_phase_scheduler
  import tlc_sched_pkg::*;
#(
  parameter int CW          = 4,
  parameter int T_MIN_GREEN = 4,
  parameter int T_EXT       = 2,
  parameter int T_MAX_GREEN = 12,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1
`ifdef TLC_PED_PHASE_EN
  ,
  parameter int T_WALK      = 6
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1,
  input  logic       p2,
  input  logic [1:0] d_main,
  output logic [2:0] m1_lt,
  output logic [2:0] m2_lt,
  output logic [2:0] s1_lt,
  output logic [2:0] s2_lt,
  output logic [1:0] phase
`ifdef TLC_PED_PHASE_EN
  ,
  input  logic       ped_req,
  output logic       walk
`endif
);

  // Last timer value of each fixed-length interval.
  localparam logic [31:0] ALLRED_END = 32'(T_ALLRED - 1);
  localparam logic [31:0] YEL_END    = 32'(T_YELLOW - 1);
  localparam logic [31:0] MIN_END    = 32'(T_MIN_GREEN - 1);
  localparam logic [31:0] MAX_END    = 32'(T_MAX_GREEN - 1);
`ifdef TLC_PED_PHASE_EN
  localparam logic [31:0] WALK_END   = 32'(T_WALK - 1);
`endif

  sched_state_t  state;
  sched_state_t  state_n;
  sched_state_t  side_sel;
  logic          req1;
  logic          req2;
`ifdef TLC_PED_PHASE_EN
  logic          reqp;
`endif
  logic          tmr_clr;
  logic [CW-1:0] timer;
  logic [31:0]   t;
  logic [31:0]   g_raw;
  logic [31:0]   g_lim;

  phase_timer #(
    .CW (CW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .count (timer)
  );

  assign t       = 32'(timer);
  assign tmr_clr = (state_n != state);

  // Main green limit follows d_main every cycle, capped at the maximum.
  always_comb begin
    g_raw = 32'(T_MIN_GREEN) + 32'(d_main) * 32'(T_EXT);
    g_lim = (g_raw > 32'(T_MAX_GREEN)) ? 32'(T_MAX_GREEN) : g_raw;
  end

  // Side selection after a clearance: s1 before s2 before main.
  always_comb begin
    if (req1)      side_sel = S1_G;
    else if (req2) side_sel = S2_G;
    else           side_sel = MAIN_G;
  end

  // Next-state decision from the current state, timer and request latches.
  always_comb begin
    state_n = state;
    case (state)
      INIT_RED: if (t == ALLRED_END) state_n = MAIN_G;
      MAIN_G:   if ((req1 | req2) && (t >= g_lim - 32'd1)) state_n = MAIN_Y;
      MAIN_Y:   if (t == YEL_END) state_n = CLR_M;
      CLR_M: begin
        if (t == ALLRED_END) begin
`ifdef TLC_PED_PHASE_EN
          if (reqp) state_n = PED_W;
          else
`endif
          state_n = side_sel;
        end
      end
`ifdef TLC_PED_PHASE_EN
      PED_W:    if (t == WALK_END) state_n = side_sel;
`endif
      S1_G:     if ((t >= MIN_END) && (!p1 || (t >= MAX_END))) state_n = S1_Y;
      S1_Y:     if (t == YEL_END) state_n = CLR_1;
      CLR_1:    if (t == ALLRED_END) state_n = req2 ? S2_G : MAIN_G;
      S2_G:     if ((t >= MIN_END) && (!p2 || (t >= MAX_END))) state_n = S2_Y;
      S2_Y:     if (t == YEL_END) state_n = CLR_2;
      CLR_2:    if (t == ALLRED_END) state_n = MAIN_G;
      default:  state_n = INIT_RED;
    endcase
  end

  // State, request latches and registered lamp/phase outputs.
  // Outputs are decoded from the next state so they change on the same
  // edge as the state itself. On entry to a green the latch clears even
  // if the request is still high (clear wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT_RED;
      req1  <= 1'b0;
      req2  <= 1'b0;
      m1_lt <= LT_RED;
      m2_lt <= LT_RED;
      s1_lt <= LT_RED;
      s2_lt <= LT_RED;
      phase <= PH_CLR;
`ifdef TLC_PED_PHASE_EN
      reqp  <= 1'b0;
      walk  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      req1  <= (state_n == S1_G && state != S1_G) ? 1'b0 : (req1 | p1);
      req2  <= (state_n == S2_G && state != S2_G) ? 1'b0 : (req2 | p2);
      m1_lt <= lamp_of(state_n, MAIN_G, MAIN_Y);
      m2_lt <= lamp_of(state_n, MAIN_G, MAIN_Y);
      s1_lt <= lamp_of(state_n, S1_G, S1_Y);
      s2_lt <= lamp_of(state_n, S2_G, S2_Y);
      phase <= phase_of(state_n);
`ifdef TLC_PED_PHASE_EN
      reqp  <= (state_n == PED_W && state != PED_W) ? 1'b0 : (reqp | ped_req);
      walk  <= (state_n == PED_W);
`endif
    end
  end

endmodule
